// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the GCD arbiter slice.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH   = 8;
  localparam int unsigned GCD_NREQ    = 4;
  localparam int unsigned GCD_STATE_W = 2;

  typedef enum logic [GCD_STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } gcd_state_t;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational rotate-priority pick: first requester above ptr, wrapping.
module gcd_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  gnt_id_c,
  output logic            any_c
);

  // Scan offsets ptr+1 .. ptr+NREQ; the first high request wins.
  always_comb begin
    gnt_c    = '0;
    gnt_id_c = '0;
    any_c    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any_c && req[j] && (j == ((32'(ptr) + k) % NREQ))) begin
          any_c    = 1'b1;
          gnt_c[j] = 1'b1;
          gnt_id_c = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine among NREQ requesters.
// Zero operands are resolved locally (result = x|y) and never reach the engine.
// Optional feature: define GCD_ARB_TIMEOUT_EN to bound the engine wait to TIMEOUT cycles.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = GCD_WIDTH,
  parameter int unsigned NREQ    = GCD_NREQ,
  parameter int unsigned IDW     = $clog2(NREQ),
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rsp_d,
  output logic                  err,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  eng_go,
  output logic [WIDTH-1:0]      eng_x,
  output logic [WIDTH-1:0]      eng_y,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_d
);

  if (NREQ < 2) begin : g_nreq_chk
    $error("gcd_arbiter: NREQ must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("gcd_arbiter: TIMEOUT must be at least 1");
  end

  gcd_state_t       state;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   gnt_id_c;
  logic             any_c;
  logic [WIDTH-1:0] x_sel_c;
  logic [WIDTH-1:0] y_sel_c;
  logic             timeout_c;

  gcd_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .gnt_c    (gnt_c),
    .gnt_id_c (gnt_id_c),
    .any_c    (any_c)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    x_sel_c = '0;
    y_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        x_sel_c = x_sel_c | req_x[i*WIDTH +: WIDTH];
        y_sel_c = y_sel_c | req_y[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] wait_cnt;

  // Wait-cycle counter: cleared while issuing, advanced every WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + TCW'(1);
    end
  end

  // High during the TIMEOUT-th WAIT cycle.
  assign timeout_c = (state == WAIT) && (wait_cnt == TCW'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Scheduler FSM with registered handshake and engine outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= IDW'(NREQ - 1);
      gnt_q    <= '0;
      grant_id <= '0;
      ack      <= '0;
      rsp_d    <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      eng_go   <= 1'b0;
      eng_x    <= '0;
      eng_y    <= '0;
    end else begin
      ack    <= '0;
      err    <= 1'b0;
      eng_go <= 1'b0;
      case (state)
        IDLE: begin
          if (any_c) begin
            grant_id <= gnt_id_c;
            gnt_q    <= gnt_c;
            busy     <= 1'b1;
            if ((x_sel_c == '0) || (y_sel_c == '0)) begin
              ack   <= gnt_c;
              rsp_d <= x_sel_c | y_sel_c;
              state <= RESP;
            end else begin
              eng_x  <= x_sel_c;
              eng_y  <= y_sel_c;
              eng_go <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            ack   <= gnt_q;
            rsp_d <= eng_d;
            state <= RESP;
          end else if (timeout_c) begin
            ack   <= gnt_q;
            rsp_d <= '0;
            err   <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          ptr   <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural subtract-loop engine.
module tb_gcd_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] d;
    logic             err;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rsp_d;
  logic                  err;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  eng_go;
  logic [WIDTH-1:0]      eng_x;
  logic [WIDTH-1:0]      eng_y;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_d;

  logic eng_done_m;
  logic spur_done;
  int   eng_lat;
  logic eng_mute;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_err;
  int   n_ack;
  int   n_go;

  assign eng_done = eng_done_m | spur_done;

  gcd_arbiter #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .ack      (ack),
    .rsp_d    (rsp_d),
    .err      (err),
    .grant_id (grant_id),
    .busy     (busy),
    .eng_go   (eng_go),
    .eng_x    (eng_x),
    .eng_y    (eng_y),
    .eng_done (eng_done),
    .eng_d    (eng_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x = a;
    logic [WIDTH-1:0] y = b;
    logic [WIDTH-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] gcd_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x = a;
    logic [WIDTH-1:0] y = b;
    if (x == 0 || y == 0) return x | y;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x;
  endfunction

  task automatic drive(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    req_x[i*WIDTH +: WIDTH] = x;
    req_y[i*WIDTH +: WIDTH] = y;
    req[i] = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] d, input logic e);
    exp_t t;
    t.ack = NREQ'(1) << i;
    t.d   = d;
    t.err = e;
    sb.push_back(t);
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < budget);
    check("ack_seen", 32'(ack != '0), 32'd1);
  endtask

  // Engine model: done pulse eng_lat WAIT cycles after the go pulse.
  initial begin
    eng_done_m = 1'b0;
    eng_d      = '0;
    forever begin
      @(negedge clk);
      if (eng_go && !eng_mute) begin
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_done_m = 1'b1;
        eng_d      = gcd_sub(eng_x, eng_y);
        @(posedge clk);
        #1;
        eng_done_m = 1'b0;
        eng_d      = '0;
      end
    end
  end

  // Output monitor: every ack pops and checks one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_go) n_go++;
      if (ack != '0) begin
        n_ack++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_vec", 32'(ack), 32'(mon_e.ack));
          check("rsp_d", 32'(rsp_d), 32'(mon_e.d));
          check("err", 32'(err), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    int n;
    int a0;
    int g0;
    logic [WIDTH-1:0] rx [NREQ];
    logic [WIDTH-1:0] ry [NREQ];
    int order [5];

    n_cmp = 0; n_err = 0; n_ack = 0; n_go = 0;
    reset = 1'b1; req = '0; req_x = '0; req_y = '0;
    eng_lat = 1; eng_mute = 1'b0; spur_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rsp_d", 32'(rsp_d), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_go", 32'(eng_go), 32'd0);
    check("rst_eng_x", 32'(eng_x), 32'd0);
    check("rst_eng_y", 32'(eng_y), 32'd0);

    // Basic transaction on requester 0
    drive(0, 8'd48, 8'd18);
    push_exp(0, 8'd6, 1'b0);
    @(negedge clk);
    check("t1_go", 32'(eng_go), 32'd1);
    check("t1_eng_x", 32'(eng_x), 32'd48);
    check("t1_eng_y", 32'(eng_y), 32'd18);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    wait_ack(20, n);
    check("t1_latency", 32'(n + 1), 32'd3);
    req = '0;
    @(negedge clk);

    // Zero-operand bypass on requester 2
    g0 = n_go;
    drive(2, 8'd0, 8'd35);
    push_exp(2, gcd_ref(8'd0, 8'd35), 1'b0);
    wait_ack(10, n);
    check("byp_latency", 32'(n), 32'd1);
    req = '0;
    @(negedge clk);
    drive(2, 8'd0, 8'd0);
    push_exp(2, gcd_ref(8'd0, 8'd0), 1'b0);
    wait_ack(10, n);
    check("byp00_latency", 32'(n), 32'd1);
    req = '0;
    @(negedge clk);
    drive(2, 8'd44, 8'd0);
    push_exp(2, gcd_ref(8'd44, 8'd0), 1'b0);
    wait_ack(10, n);
    req = '0;
    check("byp_no_go", 32'(n_go), 32'(g0));
    @(negedge clk);

    // Requester 3 drops req during WAIT; result still delivered once
    eng_lat = 4;
    a0 = n_ack;
    drive(3, 8'd91, 8'd65);
    push_exp(3, gcd_ref(8'd91, 8'd65), 1'b0);
    repeat (2) @(negedge clk);
    req[3] = 1'b0;
    wait_ack(20, n);
    check("drop_latency", 32'(n + 2), 32'd6);
    repeat (6) @(negedge clk);
    check("drop_ack_once", 32'(n_ack - a0), 32'd1);

    // All four held high: grant order 0,1,2,3,0
    eng_lat = 1;
    rx[0] = 8'd48;  ry[0] = 8'd18;
    rx[1] = 8'd100; ry[1] = 8'd75;
    rx[2] = 8'd17;  ry[2] = 8'd5;
    rx[3] = 8'd64;  ry[3] = 8'd96;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int i = 0; i < NREQ; i++) drive(i, rx[i], ry[i]);
    for (int k = 0; k < 5; k++) push_exp(order[k], gcd_ref(rx[order[k]], ry[order[k]]), 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_ack(20, n);
      check("rr_spacing", 32'(n), (k == 0) ? 32'd3 : 32'd4);
      check("rr_grant_id", 32'(grant_id), 32'(order[k]));
    end
    req = '0;
    @(negedge clk);

    // Reset asserted during WAIT
    eng_mute = 1'b1;
    @(negedge clk);
    drive(2, 8'd21, 8'd14);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_eng_x", 32'(eng_x), 32'd0);
    check("mid_rst_eng_y", 32'(eng_y), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    check("mid_rst_eng_go", 32'(eng_go), 32'd0);
    reset = 1'b0;
    eng_mute = 1'b0;
    @(negedge clk);
    drive(1, 8'd12, 8'd8);
    push_exp(1, gcd_ref(8'd12, 8'd8), 1'b0);
    wait_ack(20, n);
    check("post_rst_latency", 32'(n), 32'd3);
    req = '0;
    @(negedge clk);

    // Spurious eng_done while IDLE
    a0 = n_ack;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_no_ack", 32'(n_ack - a0), 32'd0);
    check("spur_idle", 32'(busy), 32'd0);

`ifdef GCD_ARB_TIMEOUT_EN
    // Engine never answers: timeout after 8 WAIT cycles
    eng_mute = 1'b1;
    drive(0, 8'd9, 8'd6);
    push_exp(0, 8'd0, 1'b1);
    wait_ack(30, n);
    check("to_latency", 32'(n), 32'd10);
    req = '0;
    @(negedge clk);
    eng_mute = 1'b0;
    // Done on the 8th WAIT cycle wins over the timeout
    eng_lat = 8;
    drive(1, 8'd30, 8'd12);
    push_exp(1, gcd_ref(8'd30, 8'd12), 1'b0);
    wait_ack(30, n);
    check("to_race_latency", 32'(n), 32'd10);
    req = '0;
`else
    // Without the timeout, a long engine wait still completes normally
    eng_lat = 12;
    drive(1, 8'd30, 8'd12);
    push_exp(1, gcd_ref(8'd30, 8'd12), 1'b0);
    wait_ack(40, n);
    check("long_latency", 32'(n), 32'd14);
    req = '0;
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin scheduler that shares one GCD engine (datapath plus controller, wrapped with a go/done handshake) among NREQ requesters. It latches the winning requester's operands, starts the engine, waits for completion, and returns the result with a one-cycle acknowledge. Operands of zero never reach the engine, because a subtract-loop GCD does not terminate on them; the arbiter resolves those cases locally. It sits between the requesting blocks and the single shared GCD engine instance.

## Interface
- WIDTH, 8, operand/result width
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), grant index width
- TIMEOUT, 1023, engine wait limit in cycles (used only with GCD_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  per-requester request level
- req_x  in  NREQ*WIDTH  packed X operands; requester i at [i*WIDTH +: WIDTH]
- req_y  in  NREQ*WIDTH  packed Y operands, same packing
- ack  out  NREQ  one-hot, one-cycle pulse: result valid for that requester
- rsp_d  out  WIDTH  result; valid only while ack is nonzero
- err  out  1  pulses with ack when the engine timed out
- grant_id  out  IDW  index of the requester currently served
- busy  out  1  high in every state except IDLE
- eng_go  out  1  one-cycle engine start pulse
- eng_x, eng_y  out  WIDTH  engine operands; held stable from ISSUE through WAIT
- eng_done  in  1  engine completion pulse
- eng_d  in  WIDTH  engine result; valid while eng_done is high

## Operation
- All outputs are registered. Reset values: ack=0, rsp_d=0, err=0, grant_id=0, busy=0, eng_go=0, eng_x=0, eng_y=0. State resets to IDLE. The round-robin pointer resets to NREQ-1, so requester 0 has top priority after reset.
- State machine:
  - IDLE: if any req bit is high, choose the first requester with req high, searching upward from pointer+1 and wrapping. Latch its operands and index, raise busy.
    - If either operand is 0: go to RESP with result = x|y. This gives gcd(a,0)=a and gcd(0,0)=0.
    - Otherwise go to ISSUE.
  - ISSUE: eng_go=1 for exactly one cycle; go to WAIT.
  - WAIT: hold eng_x and eng_y. When eng_done=1, capture eng_d and go to RESP.
  - RESP: ack[grant_id]=1 and rsp_d=result for one cycle. Set pointer=grant_id. Go to IDLE.
- Requester rules:
  - Hold req high and operands stable until ack.
  - Deassert req on the clock edge that ends the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- A req that drops before ack is not cancelled: the result is still delivered and ack still pulses.
- An eng_done pulse outside WAIT is ignored.
- At most one ack bit is high at any time. ack never fires for a requester whose req was low at arbitration.

## Timing
- Arbitration decision: 1 cycle (IDLE to ISSUE).
- eng_go rises in the cycle after the arbitration edge.
- Nonzero operands, with eng_done seen in WAIT cycle k: ack appears in the cycle after the done cycle. Request-to-ack = 3 + k cycles from the first IDLE sample.
- Zero bypass: ack appears in the second cycle after the first IDLE sample (IDLE, then RESP).
- Back-to-back service: RESP to IDLE to ISSUE, so the minimum issue spacing is 4 cycles when WAIT lasts 1 cycle.
- Reset asserted mid-operation: return to IDLE asynchronously and drop all outputs to their reset values. No ack is issued for the interrupted request. The engine is reset by the same reset net.

## Configuration
- GCD_ARB_TIMEOUT_EN defined:
  - A wait counter (width $clog2(TIMEOUT+1)) clears on ISSUE and increments each WAIT cycle.
  - When the counter reaches TIMEOUT with no eng_done, go to RESP with result=0 and err=1.
  - If eng_done and the timeout occur in the same cycle, eng_done wins and err=0.
- GCD_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; err is tied to 0.

## Structure
- Package gcd_pkg holds:
  - state encoding localparams: IDLE, ISSUE, WAIT, RESP
  - the default WIDTH and NREQ constants
- Sub-module gcd_rr_arbiter: combinational rotate-priority pick. Inputs are req and pointer; outputs are the one-hot grant, the grant index and an any-request flag.
- gcd_arbiter holds the state machine, operand and result registers, the pointer and the optional timeout counter.

## Test plan
- After reset, req=4'b0001 with x=48, y=18: eng_go one cycle later, operands 48/18. Engine returns 6: ack=4'b0001, rsp_d=6, err=0.
- req=4'b1111 held, each requester re-requesting immediately after its ack: grant order 0,1,2,3,0; each ack matches that requester's own operands.
- req[2] with x=0, y=35: no eng_go; ack[2] two cycles after the first sample with rsp_d=35. With x=0, y=0: rsp_d=0.
- Reset asserted during WAIT: all outputs 0 next cycle. After release, a new req[1] is served; no stale ack[old] appears.
- GCD_ARB_TIMEOUT_EN with TIMEOUT=8 and eng_done never asserted: ack with rsp_d=0, err=1 after 8 WAIT cycles. With eng_done on the 8th WAIT cycle: err=0 and the engine's result is returned.
- req[3] dropped during WAIT: ack[3] still pulses once with the correct result. A spurious eng_done in IDLE produces no ack.
